uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each single-cycle received-byte strobe, which cannot be back-pressured, into a power-of-two FIFO. It presents the bytes to the user logic over a valid/ready stream. Bytes arriving while the FIFO is full are dropped and flagged with a sticky overrun indicator.

## Interface
Parameters:
- DEPTH, 16, number of byte entries; power of two, 2..256
- AW, $clog2(DEPTH), derived address width; not overridden

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  one-cycle strobe from receiver: byte available
- in_data  in  8  received byte, qualified by in_valid
- out_valid  out  1  head byte available
- out_data  out  8  head byte, valid when out_valid
- out_ready  in  1  consumer accepts head byte
- count  out  AW+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overrun  out  1  sticky: at least one byte dropped
- overrun_clr  in  1  one-cycle clear of overrun (and drop_cnt)
- drop_cnt  out  16  number of dropped bytes (see Configuration)

## Operation
- Pointers: wr_ptr and rd_ptr, each AW+1 bits. Low AW bits address storage; MSB is the wrap bit.
- count = wr_ptr - rd_ptr, modulo 2^(AW+1). empty when pointers are equal. full when low bits are equal and MSBs differ.
- Pop: out_valid & out_ready. rd_ptr increments.
- Push: in_valid & (~full | pop). Memory is written at wr_ptr[AW-1:0]; wr_ptr increments.
- Full with simultaneous push and pop: both happen, count stays DEPTH, nothing is dropped.
- Drop: in_valid & full & ~pop. The byte is discarded, pointers are unchanged, overrun is set.
- overrun_clr and drop in the same cycle: set wins, so overrun stays 1.
- Empty with in_valid and out_ready in the same cycle: no bypass. The byte is written and appears on out_valid next cycle.
- out_valid = ~empty. out_data = mem[rd_ptr[AW-1:0]] (first-word fall-through). out_data must stay stable while out_valid & ~out_ready.
- in_data is ignored when in_valid = 0.
- Reset values: wr_ptr = rd_ptr = 0, out_valid = 0, count = 0, empty = 1, full = 0, overrun = 0, drop_cnt = 0. Storage contents are not reset.
- Reset mid-operation: all buffered bytes are discarded immediately.

## Timing
- in_valid sampled at edge N → out_valid = 1 and out_data = byte after edge N (1-cycle latency).
- Pop at edge N → next entry on out_data after edge N. Back-to-back pops sustain 1 byte per cycle.
- count, full and empty are registered-pointer derived and update in the cycle after the push or pop edge.
- overrun asserts in the cycle after the dropping edge. It deasserts in the cycle after an overrun_clr edge that has no concurrent drop.

## Configuration
- UART_RX_FIFO_DROP_CNT_EN defined:
  - drop_cnt increments on every drop and saturates at 16'hFFFF.
  - overrun_clr resets drop_cnt to 0. A drop in the same cycle leaves drop_cnt = 1.
- UART_RX_FIFO_DROP_CNT_EN undefined:
  - drop_cnt is tied to 0 and no counter logic is generated.
  - The port stays present so the interface is identical in both builds.

## Structure
- Shared package uart_pkg:
  - localparam UART_DW = 8
  - typedef logic [UART_DW-1:0] uart_byte_t, used for in_data, out_data and storage
- Sub-module uart_fifo_mem:
  - DEPTH×8 simple dual-port storage
  - synchronous write (we, waddr, wdata), asynchronous read (raddr, rdata)
  - keeps the storage inferable and swappable for distributed RAM
- Pointer, flag and overrun logic live in uart_rx_fifo.

## Test plan
- Single byte: in_valid with 8'hA5, out_ready = 0 → next cycle out_valid = 1, out_data = 8'hA5, count = 1. Raise out_ready → empty = 1 the cycle after.
- Fill (DEPTH = 16): push 8'h00..8'h0F, no pops → full = 1, count = 16. Drain → the same 16 bytes in order, then empty = 1.
- Overrun: full, push 8'hEE with out_ready = 0 → overrun = 1, count = 16, 8'hEE never appears. With the macro, drop_cnt = 1.
- Full push+pop: full, in_valid 8'h77 with out_ready = 1 in the same cycle → overrun stays 0, count = 16, 8'h77 is the last byte drained.
- Clear race: overrun = 1, drop and overrun_clr in the same cycle → overrun = 1 (drop_cnt = 1 with the macro). overrun_clr alone → overrun = 0, drop_cnt = 0.
- Reset mid-stream: 5 bytes buffered, pulse rst → out_valid = 0, count = 0 immediately. The next push 8'h3C is the first byte out.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART data types.
//   UART_DW     - width of one UART data byte
//   uart_byte_t - one received byte, used for FIFO data ports and storage
package uart_pkg;

    localparam int unsigned UART_DW = 8;

    typedef logic [UART_DW-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x 8 simple dual-port byte storage.
// Synchronous write, asynchronous read. It is kept separate so that it can be
// inferred as, or swapped for, distributed RAM. Contents are not reset.
// Ports:
//   clk      - write clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - read data (combinational from i_raddr)
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  uart_byte_t    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output uart_byte_t    o_rdata
);

    uart_byte_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO behind the UART receiver.
// The receiver strobe cannot be stalled. A byte that arrives while the FIFO is
// full and not popping in the same cycle is dropped, and this sets the sticky
// overrun flag. Output is a first-word fall-through valid/ready stream.
// Optional feature macro: UART_RX_FIFO_DROP_CNT_EN enables the saturating
// 16-bit dropped-byte counter. When the macro is undefined, drop_cnt is tied
// to 0.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid, in_data     - one-cycle received-byte strobe and byte
//   out_valid, out_data   - head byte of the FIFO
//   out_ready             - consumer accepts the head byte
//   count, full, empty    - occupancy, derived from the registered pointers
//   overrun, overrun_clr  - sticky drop flag and its one-cycle clear
//   drop_cnt              - number of dropped bytes (0 when the feature is off)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  uart_byte_t  in_data,
    output logic        out_valid,
    output uart_byte_t  out_data,
    input  logic        out_ready,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty,
    output logic        overrun,
    input  logic        overrun_clr,
    output logic [15:0] drop_cnt
);

    localparam logic [AW:0] PtrOne = (AW+1)'(1);

    // The pointer MSB is the wrap bit. It tells full apart from empty.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_overrun;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop   = ~w_empty & out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign w_push  = in_valid & (~w_full | w_pop);
    assign w_drop  = in_valid & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
        end
    end

    // A drop takes priority over a concurrent clear, so no loss goes unreported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (overrun_clr) begin
            r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 16'd0;
`endif

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (out_data)
    );

    assign out_valid = ~w_empty;
    assign count     = r_wr_ptr - r_rd_ptr;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overrun   = r_overrun;

endmodule : uart_rx_fifo
